// File: rtl/relu_maxpool.sv
// ReLU + 2x2 stride-2 max-pool stage: reads a signed Q16.16 IN_W x IN_W map from M1
// and writes the OUT_W x OUT_W pooled result to M2, once per start.
module relu_maxpool #(
    parameter int IN_W  = 26,
    parameter int OUT_W = 13,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          finish,
    output logic          M1_R_req,
    output logic [31:0]   M1_addr,
    input  logic [DW-1:0] M1_R_data,
    output logic [3:0]    M1_W_req,
    output logic [DW-1:0] M1_W_data,
    output logic          M2_R_req,
    output logic [31:0]   M2_addr,
    input  logic [DW-1:0] M2_R_data,
    output logic [3:0]    M2_W_req,
    output logic [DW-1:0] M2_W_data
);

    localparam int CW = $clog2(OUT_W);
    localparam logic [CW-1:0] LAST = CW'(OUT_W - 1);

    typedef enum logic [2:0] {
        IDLE, RD0, RD1, RD2, RD3, DRAIN, WR, DONE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] r, r_n, c, c_n;
    logic [DW-1:0] acc, acc_n, upd;
    logic          finish_n, m1_req_n;
    logic [31:0]   m1_addr_n, m2_addr_n;
    logic [3:0]    m2_we_n;
    logic [DW-1:0] m2_data_n;
    logic          unused_m2_rdata;

    assign M1_W_req        = '0;
    assign M1_W_data       = '0;
    assign M2_R_req        = 1'b0;
    assign unused_m2_rdata = ^M2_R_data;

    // Byte address of window element k: bit 1 selects the row, bit 0 the column.
    function automatic logic [31:0] rd_addr(input logic [CW-1:0] rr,
                                            input logic [CW-1:0] cc,
                                            input logic [1:0]    k);
        logic [31:0] y, x;
        y = 32'(rr) * 32'd2 + 32'(k[1]);
        x = 32'(cc) * 32'd2 + 32'(k[0]);
        return (y * 32'(IN_W) + x) << 2;
    endfunction

    function automatic logic [31:0] wr_addr(input logic [CW-1:0] rr,
                                            input logic [CW-1:0] cc);
        return (32'(rr) * 32'(OUT_W) + 32'(cc)) << 2;
    endfunction

    always_comb begin
        upd = ($signed(M1_R_data) > $signed(acc)) ? M1_R_data : acc;
    end

    // Outputs are computed one state ahead so they can be registered.
    always_comb begin
        state_n   = state;
        r_n       = r;
        c_n       = c;
        acc_n     = acc;
        finish_n  = finish;
        m1_req_n  = 1'b0;
        m1_addr_n = '0;
        m2_we_n   = '0;
        m2_addr_n = '0;
        m2_data_n = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    finish_n  = 1'b0;
                    r_n       = '0;
                    c_n       = '0;
                    acc_n     = '0;
                    state_n   = RD0;
                    m1_req_n  = 1'b1;
                    m1_addr_n = rd_addr('0, '0, 2'd0);
                end
            end
            RD0: begin
                state_n   = RD1;
                m1_req_n  = 1'b1;
                m1_addr_n = rd_addr(r, c, 2'd1);
            end
            RD1: begin
                acc_n     = upd;
                state_n   = RD2;
                m1_req_n  = 1'b1;
                m1_addr_n = rd_addr(r, c, 2'd2);
            end
            RD2: begin
                acc_n     = upd;
                state_n   = RD3;
                m1_req_n  = 1'b1;
                m1_addr_n = rd_addr(r, c, 2'd3);
            end
            RD3: begin
                acc_n   = upd;
                state_n = DRAIN;
            end
            DRAIN: begin
                acc_n     = upd;
                state_n   = WR;
                m2_we_n   = 4'b1111;
                m2_addr_n = wr_addr(r, c);
                m2_data_n = upd;
            end
            WR: begin
                if (r == LAST && c == LAST) begin
                    state_n  = DONE;
                    finish_n = 1'b1;
                end else begin
                    if (c == LAST) begin
                        c_n = '0;
                        r_n = r + 1'b1;
                    end else begin
                        c_n = c + 1'b1;
                    end
                    acc_n     = '0;
                    state_n   = RD0;
                    m1_req_n  = 1'b1;
                    m1_addr_n = rd_addr(r_n, c_n, 2'd0);
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            r         <= '0;
            c         <= '0;
            acc       <= '0;
            finish    <= 1'b0;
            M1_R_req  <= 1'b0;
            M1_addr   <= '0;
            M2_W_req  <= '0;
            M2_addr   <= '0;
            M2_W_data <= '0;
        end else begin
            state     <= state_n;
            r         <= r_n;
            c         <= c_n;
            acc       <= acc_n;
            finish    <= finish_n;
            M1_R_req  <= m1_req_n;
            M1_addr   <= m1_addr_n;
            M2_W_req  <= m2_we_n;
            M2_addr   <= m2_addr_n;
            M2_W_data <= m2_data_n;
        end
    end

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool: synchronous M1/M2 memory models, protocol monitor,
// and immediate-assertion checks against hand-computed results.
module tb_relu_maxpool;

    logic        clk, rst, start, finish;
    logic        M1_R_req, M2_R_req;
    logic [31:0] M1_addr, M1_R_data, M1_W_data, M2_addr, M2_R_data, M2_W_data;
    logic [3:0]  M1_W_req, M2_W_req;

    relu_maxpool #(.IN_W(26), .OUT_W(13), .DW(32)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .M1_R_req(M1_R_req), .M1_addr(M1_addr), .M1_R_data(M1_R_data),
        .M1_W_req(M1_W_req), .M1_W_data(M1_W_data),
        .M2_R_req(M2_R_req), .M2_addr(M2_addr), .M2_R_data(M2_R_data),
        .M2_W_req(M2_W_req), .M2_W_data(M2_W_data)
    );

    logic [31:0] m1 [676];
    logic [31:0] m2 [169];
    int          m2_run [169];
    int          run_id;
    int          total, bad;
    int          rd_cnt, wr_cnt, ovl_cnt, m1w_cnt, oob_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign M2_R_data = 32'h0;

    // Synchronous memories: address in cycle k, data during cycle k+1.
    always @(posedge clk) begin
        M1_R_data <= (M1_addr < 32'd2704) ? m1[int'(M1_addr >> 2)] : 32'h0;
        if (M2_W_req == 4'hF && M2_addr < 32'd676) begin
            m2[int'(M2_addr >> 2)]     <= M2_W_data;
            m2_run[int'(M2_addr >> 2)] <= run_id;
        end
    end

    initial begin
        rd_cnt = 0; wr_cnt = 0; ovl_cnt = 0; m1w_cnt = 0; oob_cnt = 0;
    end

    always @(negedge clk) begin
        if (M1_R_req) rd_cnt++;
        if (M2_W_req != 4'h0) wr_cnt++;
        if (M1_R_req && M2_W_req != 4'h0) ovl_cnt++;
        if (M1_W_req != 4'h0) m1w_cnt++;
        if (M1_R_req && M1_addr > 32'hA8C) oob_cnt++;
        if (M2_W_req != 4'h0 && (M2_addr > 32'h2A0 || M2_W_req != 4'hF)) oob_cnt++;
    end

    // Entries not written during the current run read back as a sentinel.
    function automatic logic [31:0] m2_get(input int i);
        return (m2_run[i] == run_id) ? m2[i] : 32'hDEADBEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill_m1(input logic [31:0] v);
        for (int i = 0; i < 676; i++) m1[i] = v;
    endtask

    task automatic set_win(input int r, input int c, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] d0, input logic [31:0] d1);
        m1[(2*r)*26 + 2*c]       = a;
        m1[(2*r)*26 + 2*c + 1]   = b;
        m1[(2*r+1)*26 + 2*c]     = d0;
        m1[(2*r+1)*26 + 2*c + 1] = d1;
    endtask

    // Start is accepted on the posedge; returns at the first negedge after it (cycle 1).
    task automatic start_pulse();
        run_id++;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_finish(output int lat);
        int n;
        n = 1;
        while (!finish && n < 2000) begin
            @(negedge clk);
            n++;
        end
        lat = finish ? n : -1;
        repeat (2) @(negedge clk);
    endtask

    task automatic run(output int lat);
        start_pulse();
        wait_finish(lat);
    endtask

    task automatic check_ramp(input string tag);
        int errs;
        errs = 0;
        for (int r = 0; r < 13; r++)
            for (int c = 0; c < 13; c++)
                if (m2_get(r*13 + c) !== 32'(((2*r+1)*26 + 2*c + 1) << 16)) errs++;
        check(tag, 32'(errs), 32'd0);
    endtask

    initial begin
        int lat, rd0, wr0, errs;
        logic [31:0] w [4];
        total = 0; bad = 0; run_id = 0;
        for (int i = 0; i < 169; i++) begin m2[i] = 32'h0; m2_run[i] = -1; end
        rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_finish",   32'(finish),    32'd0);
        check("rst_m1_req",   32'(M1_R_req),  32'd0);
        check("rst_m1_addr",  M1_addr,        32'd0);
        check("rst_m2_we",    32'(M2_W_req),  32'd0);
        check("rst_m2_addr",  M2_addr,        32'd0);
        check("rst_m2_data",  M2_W_data,      32'd0);
        check("rst_m1_wdata", M1_W_data,      32'd0);
        check("rst_m2_rreq",  32'(M2_R_req),  32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // All-negative map
        fill_m1(32'hFFFF0000);
        rd0 = rd_cnt; wr0 = wr_cnt;
        run(lat);
        check("neg_latency", 32'(lat), 32'd1015);
        check("neg_reads",   32'(rd_cnt - rd0), 32'd676);
        check("neg_writes",  32'(wr_cnt - wr0), 32'd169);
        errs = 0;
        for (int i = 0; i < 169; i++) if (m2_get(i) !== 32'h0) errs++;
        check("neg_all_zero", 32'(errs), 32'd0);
        check("finish_held",  32'(finish), 32'd1);

        // Ramp map
        for (int i = 0; i < 676; i++) m1[i] = 32'(i) << 16;
        run(lat);
        check("ramp_latency", 32'(lat), 32'd1015);
        check("ramp_m2_0",    m2_get(0),   32'h001B0000);
        check("ramp_m2_168",  m2_get(168), 32'h02A30000);
        check_ramp("ramp_all");

        // Max position sweep, window (0,0) and boundary window (12,12)
        for (int p = 0; p < 4; p++) begin
            w[0] = 32'h00010000; w[1] = 32'h00030000; w[2] = 32'h00020000; w[3] = 32'h00010000;
            w[p] = 32'h00050000;
            fill_m1(32'hFFFF0000);
            set_win(0, 0, w[0], w[1], w[2], w[3]);
            set_win(12, 12, w[3], w[2], w[1], w[0]);
            run(lat);
            check($sformatf("pos%0d_w0", p),   m2_get(0),   32'h00050000);
            check($sformatf("pos%0d_w168", p), m2_get(168), 32'h00050000);
            check($sformatf("pos%0d_w1", p),   m2_get(1),   32'h00000000);
        end

        // Signed comparisons
        fill_m1(32'hFFFF0000);
        set_win(0, 0, 32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h0);
        set_win(12, 12, 32'h80000000, 32'hFFFFFFFF, 32'h80000001, 32'hFFFF0000);
        run(lat);
        check("signed_max", m2_get(0),   32'h7FFFFFFF);
        check("signed_neg", m2_get(168), 32'h00000000);

        // Reset mid-run
        for (int i = 0; i < 676; i++) m1[i] = 32'(i) << 16;
        start_pulse();
        repeat (499) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_finish",  32'(finish),   32'd0);
        check("mid_rst_m1_req",  32'(M1_R_req), 32'd0);
        check("mid_rst_m1_addr", M1_addr,       32'd0);
        check("mid_rst_m2_we",   32'(M2_W_req), 32'd0);
        check("mid_rst_m2_addr", M2_addr,       32'd0);
        check("mid_rst_m2_data", M2_W_data,     32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wr0 = wr_cnt; rd0 = rd_cnt;
        repeat (20) @(negedge clk);
        check("post_rst_no_wr", 32'(wr_cnt - wr0), 32'd0);
        check("post_rst_no_rd", 32'(rd_cnt - rd0), 32'd0);
        check("post_rst_fin",   32'(finish),       32'd0);
        rd0 = rd_cnt; wr0 = wr_cnt;
        run(lat);
        check("rerun_latency", 32'(lat), 32'd1015);
        check("rerun_reads",   32'(rd_cnt - rd0), 32'd676);
        check("rerun_writes",  32'(wr_cnt - wr0), 32'd169);
        check_ramp("rerun_ramp");

        // Protocol totals across every run
        check("m1_wreq_zero", 32'(m1w_cnt), 32'd0);
        check("req_overlap",  32'(ovl_cnt), 32'd0);
        check("addr_range",   32'(oob_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/relu_maxpool.md
# relu_maxpool

Post-convolution stage: reads the 26x26 signed Q16.16 feature map that the convolution stage writes to memory M1, applies ReLU and 2x2 stride-2 max-pooling, and writes the 13x13 result to memory M2. It runs once per `start` and is started after the convolution stage raises its `finish`.

## Interface
Parameters:
- `IN_W`, 26: input map width and height, in words.
- `OUT_W`, 13: output map width and height; must equal `IN_W/2`.
- `DW`, 32: data word width; signed Q16.16.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: run request, sampled only in IDLE.
- `finish`, output, 1: run complete.
- `M1_R_req`, output, 1: M1 read strobe.
- `M1_addr`, output, 32: M1 byte address.
- `M1_R_data`, input, 32: M1 read data.
- `M1_W_req`, output, 4: M1 byte-write enables; tied to 0.
- `M1_W_data`, output, 32: tied to 0.
- `M2_R_req`, output, 1: tied to 0.
- `M2_addr`, output, 32: M2 byte address.
- `M2_R_data`, input, 32: unused.
- `M2_W_req`, output, 4: M2 byte-write enables.
- `M2_W_data`, output, 32: M2 write data.

## Operation
- Memory model: synchronous, word-addressed by byte address (index*4). An address driven in cycle k returns data during cycle k+1. The block samples that data on the edge ending cycle k+1.
- Input element (y,x) lives at M1 byte address (y*IN_W+x)*4. Output element (r,c) goes to M2 byte address (r*OUT_W+c)*4.
- Windows are processed in raster order: r = 0..12 outer, c = 0..12 inner.
- Each window reads four elements in this order: (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
- Result = signed max(0, a, b, c, d). The accumulator is cleared to 0 at the start of each window, so ReLU is implicit.
- Comparisons are signed 32-bit. No rounding or saturation is needed.
- FSM states:
  - IDLE: all strobes low. If `start`=1, clear `finish`, set r=c=0, go to RD0.
  - RD0..RD3: drive `M1_R_req`=1 and `M1_addr` for element 0..3, one per cycle.
    - Clear the accumulator on entry to RD0.
    - Update the accumulator with the returned data on the edges ending RD1, RD2, RD3 and DRAIN.
  - DRAIN: `M1_R_req`=0; capture element 3.
  - WR: `M2_W_req`=4'b1111, `M2_addr`/`M2_W_data` = result; `M1_R_req`=0.
    - If (r,c)=(12,12), go to DONE.
    - Otherwise advance c, wrapping to 0 and incrementing r at c=12, then go to RD0.
  - DONE: `finish`=1, go to IDLE. `finish` stays high until the next accepted `start`.
- `M1_R_req` and `M2_W_req` are never active in the same cycle. `M2_W_req` is 0 outside WR.

## Timing
- Reset values, all outputs: 0. Counters are 0, the accumulator is 0, and the FSM is in IDLE.
- Asserting `rst` mid-run aborts immediately. No partial write completes after reset; the run restarts only on a new `start`.
- Per-window cost: 6 cycles (RD0-RD3, DRAIN, WR).
- Full run: 169*6 = 1014 cycles from the edge that accepts `start` to the last WR cycle. `finish` rises on the following edge, at cycle 1015.
- `start` is ignored outside IDLE. A `start` held high through DONE re-triggers a new run on the next IDLE cycle.
- All outputs are registered and change only on `clk` edges or on the asynchronous reset.

## Test plan
- All-negative map (every word 0xFFFF0000 = -1.0): after `start`, all 169 M2 words = 0x00000000, and `finish` rises exactly 1015 cycles after `start` is accepted.
- Ramp map, M1[i] = i<<16: M2[r*13+c] = ((2r+1)*26 + 2c+1)<<16. Check M2[0]=0x001B0000 and M2[168]=0x02A30000.
- Max position sweep: window 0 = {0x00010000, 0x00050000, 0x00030000, 0x00020000} -> M2[0]=0x00050000. Repeat with the max at each of the four positions; boundary window (12,12) checked likewise at M2 byte address 0x2A0.
- Signed compare: window = {0x7FFFFFFF, 0x80000000, 0, 0} -> 0x7FFFFFFF. Window = {0x80000000, 0xFFFFFFFF, 0x80000001, 0xFFFF0000} -> 0.
- Protocol checks:
  - `M1_W_req`=0 throughout the run.
  - `M1_R_req` and `M2_W_req` are never simultaneously active.
  - Exactly 676 reads and 169 writes occur.
  - Read addresses stay in 0..0xA8C and write addresses in 0..0x2A0.
- Reset mid-run: drop `rst` at cycle 500 for 2 cycles. All outputs read 0 immediately. No further writes occur until a new `start`, after which M2 matches the reference results.
